// File: rtl/intra_mb_pred_parser.sv
// -----------------------------------------------------------------------------
// intra_mb_pred_parser
//
// Parses the mb_pred() syntax of an intra macroblock straight out of the
// bitstream buffer window. For I_NxN macroblocks it walks the 16 luma 4x4
// blocks, presenting prev_intra4x4_pred_mode_flag and (when the flag is 0)
// rem_intra4x4_pred_mode to the downstream Intra4x4 mode decoder one block
// at a time. It then decodes intra_chroma_pred_mode (ue(v)). I16x16
// macroblocks only parse the chroma mode. The number of bits consumed in
// each cycle is reported on pc_advance for the bitstream pointer logic.
//
// State | meaning
// ------+-------------------------------------------------------------
//   0   | idle: waiting for start
//   1   | prev_intra4x4_pred_mode_flag of block luma4x4BlkIdx on window
//   2   | rem_intra4x4_pred_mode of block luma4x4BlkIdx on window
//   3   | intra_chroma_pred_mode ue(v) on window
//   4   | mb_pred done pulse
//   5   | wait for bits_avail, then resume at the recorded state
//
// Ports:
//   clk, reset_n                 clock, synchronous active-low reset
//   start                        one-cycle pulse, begin mb_pred of current MB
//   mb_is_I4x4                   1: I_NxN, 0: I16x16 (sampled on start)
//   bits_avail                   window holds >=16 valid bits
//   BitStream_buffer_output      window, MSB is the next bit
//   mb_pred_state                registered state code (table above)
//   luma4x4BlkIdx                registered current 4x4 block index
//   prev_intra4x4_pred_mode_flag window[15] in state 1, else 0
//   rem_intra4x4_pred_mode       window[15:13] in state 2, else 0
//   intra_chroma_pred_mode       registered decoded chroma mode
//   pc_advance                   bits consumed this cycle
//   mb_pred_done                 high in state 4
//   mb_pred_error                pulse on illegal chroma code
// -----------------------------------------------------------------------------
module intra_mb_pred_parser (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        mb_is_I4x4,
  input  logic        bits_avail,
  input  logic [15:0] BitStream_buffer_output,
  output logic [2:0]  mb_pred_state,
  output logic [3:0]  luma4x4BlkIdx,
  output logic        prev_intra4x4_pred_mode_flag,
  output logic [2:0]  rem_intra4x4_pred_mode,
  output logic [1:0]  intra_chroma_pred_mode,
  output logic [2:0]  pc_advance,
  output logic        mb_pred_done,
  output logic        mb_pred_error
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_PREV   = 3'd1,
    S_REM    = 3'd2,
    S_CHROMA = 3'd3,
    S_DONE   = 3'd4,
    S_WAIT   = 3'd5
  } state_t;

  state_t     state, state_nxt;
  state_t     ret_state, ret_state_nxt;
  state_t     target;
  logic       go;
  logic [3:0] blk, blk_nxt;
  logic [1:0] chroma, chroma_nxt;

  // ue(v) decode of the chroma mode from the top five window bits
  logic [4:0] code;
  logic [1:0] dec_mode;
  logic [2:0] dec_pc;
  logic       dec_err;

  // only the top five window bits are ever inspected
  logic unused_window_bits;
  assign unused_window_bits = ^BitStream_buffer_output[10:0];

  assign code = BitStream_buffer_output[15:11];

  always_comb begin
    dec_mode = 2'd0;
    dec_pc   = 3'd5;
    dec_err  = 1'b0;
    if (code[4]) begin
      dec_mode = 2'd0;
      dec_pc   = 3'd1;
    end else if (code[3]) begin
      dec_mode = code[2] ? 2'd2 : 2'd1;
      dec_pc   = 3'd3;
    end else if (code == 5'b00100) begin
      dec_mode = 2'd3;
      dec_pc   = 3'd5;
    end else begin
      dec_err  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      ret_state <= S_IDLE;
      blk       <= 4'd0;
      chroma    <= 2'd0;
    end else begin
      state     <= state_nxt;
      ret_state <= ret_state_nxt;
      blk       <= blk_nxt;
      chroma    <= chroma_nxt;
    end
  end

  always_comb begin
    state_nxt                    = state;
    ret_state_nxt                = ret_state;
    blk_nxt                      = blk;
    chroma_nxt                   = chroma;
    target                       = S_IDLE;
    go                           = 1'b0;
    pc_advance                   = 3'd0;
    prev_intra4x4_pred_mode_flag = 1'b0;
    rem_intra4x4_pred_mode       = 3'd0;
    mb_pred_done                 = 1'b0;
    mb_pred_error                = 1'b0;

    case (state)
      S_IDLE: begin
        if (start) begin
          blk_nxt = 4'd0;
          target  = mb_is_I4x4 ? S_PREV : S_CHROMA;
          go      = 1'b1;
        end
      end
      S_PREV: begin
        pc_advance                   = 3'd1;
        prev_intra4x4_pred_mode_flag = BitStream_buffer_output[15];
        go                           = 1'b1;
        if (!BitStream_buffer_output[15]) begin
          target = S_REM;
        end else if (blk != 4'd15) begin
          blk_nxt = blk + 4'd1;
          target  = S_PREV;
        end else begin
          target  = S_CHROMA;
        end
      end
      S_REM: begin
        pc_advance             = 3'd3;
        rem_intra4x4_pred_mode = BitStream_buffer_output[15:13];
        go                     = 1'b1;
        if (blk != 4'd15) begin
          blk_nxt = blk + 4'd1;
          target  = S_PREV;
        end else begin
          target  = S_CHROMA;
        end
      end
      S_CHROMA: begin
        pc_advance    = dec_pc;
        mb_pred_error = dec_err;
        chroma_nxt    = dec_mode;
        state_nxt     = S_DONE;
      end
      S_DONE: begin
        mb_pred_done = 1'b1;
        blk_nxt      = 4'd0;
        state_nxt    = S_IDLE;
      end
      S_WAIT: begin
        if (bits_avail) begin
          state_nxt = ret_state;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase

    // entry into any window-reading state needs a full window; the block
    // index was already advanced above, so the wait state only needs the
    // destination to resume without repeating a block
    if (go) begin
      if (bits_avail) begin
        state_nxt = target;
      end else begin
        state_nxt     = S_WAIT;
        ret_state_nxt = target;
      end
    end
  end

  assign mb_pred_state          = state;
  assign luma4x4BlkIdx          = blk;
  assign intra_chroma_pred_mode = chroma;

endmodule

// File: tb/tb_intra_mb_pred_parser.sv
module tb_intra_mb_pred_parser;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic        mb_is_I4x4;
  logic        bits_avail;
  logic [15:0] BitStream_buffer_output;
  logic [2:0]  mb_pred_state;
  logic [3:0]  luma4x4BlkIdx;
  logic        prev_intra4x4_pred_mode_flag;
  logic [2:0]  rem_intra4x4_pred_mode;
  logic [1:0]  intra_chroma_pred_mode;
  logic [2:0]  pc_advance;
  logic        mb_pred_done;
  logic        mb_pred_error;

  intra_mb_pred_parser dut (
    .clk                          (clk),
    .reset_n                      (reset_n),
    .start                        (start),
    .mb_is_I4x4                   (mb_is_I4x4),
    .bits_avail                   (bits_avail),
    .BitStream_buffer_output      (BitStream_buffer_output),
    .mb_pred_state                (mb_pred_state),
    .luma4x4BlkIdx                (luma4x4BlkIdx),
    .prev_intra4x4_pred_mode_flag (prev_intra4x4_pred_mode_flag),
    .rem_intra4x4_pred_mode       (rem_intra4x4_pred_mode),
    .intra_chroma_pred_mode       (intra_chroma_pred_mode),
    .pc_advance                   (pc_advance),
    .mb_pred_done                 (mb_pred_done),
    .mb_pred_error                (mb_pred_error)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // one syntax element as the downstream decoder should see it
  typedef struct {
    int st;
    int blk;
    int flag;
    int rem;
    int pc;
    int err;
    int mode;
  } elem_t;

  elem_t el[$];
  bit    bs[$];
  int    ptr;
  int    exp_mode;

  typedef struct {
    logic [15:0] win;
    int          mode;
    int          pc;
    int          err;
  } cvec_t;

  cvec_t tbl[$];

  task automatic push_bits(input int v, input int n);
    for (int i = n - 1; i >= 0; i--) bs.push_back(v[i]);
  endtask

  function automatic logic [15:0] cur_win();
    logic [15:0] w;
    w = 16'd0;
    for (int i = 0; i < 16; i++)
      if (ptr + i < bs.size()) w[15-i] = bs[ptr+i];
    return w;
  endfunction

  // flag_mode: 0 random flags, 1 all flags 1, 2 all 1 except block 3 (rem 3)
  // ccat: chroma category 0..3 = mode, 4 = illegal code, -1 random
  task automatic build(input bit i4, input int flag_mode, input int ccat);
    int f, r, cat, sub, mode, pc, err;
    el.delete();
    bs.delete();
    ptr = 0;
    if (i4) begin
      for (int b = 0; b < 16; b++) begin
        if (flag_mode == 1)      f = 1;
        else if (flag_mode == 2) f = (b == 3) ? 0 : 1;
        else                     f = $urandom_range(0, 1);
        push_bits(f, 1);
        el.push_back('{1, b, f, 0, 1, 0, 0});
        if (f == 0) begin
          r = (flag_mode == 2) ? 3 : $urandom_range(0, 7);
          push_bits(r, 3);
          el.push_back('{2, b, 0, r, 3, 0, 0});
        end
      end
    end
    cat = (ccat < 0) ? $urandom_range(0, 4) : ccat;
    err = 0;
    case (cat)
      0: begin push_bits(1, 1); push_bits($urandom_range(0, 15), 4); mode = 0; pc = 1; end
      1: begin push_bits(2, 3); push_bits($urandom_range(0, 3), 2); mode = 1; pc = 3; end
      2: begin push_bits(3, 3); push_bits($urandom_range(0, 3), 2); mode = 2; pc = 3; end
      3: begin push_bits(4, 5); mode = 3; pc = 5; end
      default: begin
        sub = $urandom_range(0, 2);
        if (sub == 0)      push_bits(5, 5);
        else if (sub == 1) begin push_bits(3, 4); push_bits($urandom_range(0, 1), 1); end
        else               begin push_bits(0, 3); push_bits($urandom_range(0, 3), 2); end
        mode = 0; pc = 5; err = 1;
      end
    endcase
    el.push_back('{3, i4 ? 15 : 0, 0, 0, pc, err, mode});
    push_bits($urandom_range(0, 65535), 16);
  endtask

  function automatic logic rnd_ba(input int pct);
    return ($urandom_range(0, 99) < pct);
  endfunction

  // Plays the element list through the DUT. An element is presented in the
  // cycle after a cycle with bits_avail=1; otherwise the DUT should wait.
  task automatic run_mb(input bit i4, input int pct, input int stall_k, output int done_cyc);
    int    k, cyc, stall;
    logic  prev_ba, is_el;
    elem_t e;
    cyc = 0; k = 0; stall = 0;
    start = 1'b1;
    mb_is_I4x4 = i4;
    bits_avail = rnd_ba(pct);
    BitStream_buffer_output = cur_win();
    #1;
    chk("idle_state", mb_pred_state, 0);
    chk("idle_pc", pc_advance, 0);
    prev_ba = bits_avail;
    while (k < el.size()) begin
      @(posedge clk); #1;
      cyc++;
      is_el = prev_ba;
      start = (is_el && el[k].st == 2) ? 1'b1 : ($urandom_range(0, 5) == 0);
      mb_is_I4x4 = $urandom_range(0, 1);
      if (is_el && k == stall_k) stall = 3;
      if (stall > 0) begin bits_avail = 1'b0; stall--; end
      else bits_avail = rnd_ba(pct);
      BitStream_buffer_output = cur_win();
      #1;
      chk("chroma_hold", intra_chroma_pred_mode, exp_mode);
      chk("done_low", mb_pred_done, 0);
      if (is_el) begin
        e = el[k];
        chk("el_state", mb_pred_state, e.st);
        chk("el_blk", luma4x4BlkIdx, e.blk);
        chk("el_flag", prev_intra4x4_pred_mode_flag, (e.st == 1) ? e.flag : 0);
        chk("el_rem", rem_intra4x4_pred_mode, (e.st == 2) ? e.rem : 0);
        chk("el_pc", pc_advance, e.pc);
        chk("el_err", mb_pred_error, e.err);
        ptr += e.pc;
        if (e.st == 3) exp_mode = e.mode;
        k++;
      end else begin
        chk("wait_state", mb_pred_state, 5);
        chk("wait_pc", pc_advance, 0);
        chk("wait_flag", prev_intra4x4_pred_mode_flag, 0);
        chk("wait_rem", rem_intra4x4_pred_mode, 0);
        chk("wait_err", mb_pred_error, 0);
      end
      prev_ba = bits_avail;
      if (cyc > 3000) begin
        chk("mb_cycle_budget", cyc, 0);
        break;
      end
    end
    @(posedge clk); #1;
    cyc++;
    start = 1'b1;
    bits_avail = $urandom_range(0, 1);
    #1;
    chk("done_state", mb_pred_state, 4);
    chk("done_pulse", mb_pred_done, 1);
    chk("done_pc", pc_advance, 0);
    chk("done_err", mb_pred_error, 0);
    chk("done_chroma", intra_chroma_pred_mode, exp_mode);
    done_cyc = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    #1;
    chk("post_state", mb_pred_state, 0);
    chk("post_blk", luma4x4BlkIdx, 0);
    chk("post_done", mb_pred_done, 0);
    chk("post_chroma", intra_chroma_pred_mode, exp_mode);
  endtask

  initial begin
    int dc;
    int last_mode;

    tbl.push_back('{16'h8000, 0, 1, 0});
    tbl.push_back('{16'hF800, 0, 1, 0});
    tbl.push_back('{16'h4000, 1, 3, 0});
    tbl.push_back('{16'h5800, 1, 3, 0});
    tbl.push_back('{16'h6000, 2, 3, 0});
    tbl.push_back('{16'h7FFF, 2, 3, 0});
    tbl.push_back('{16'h2000, 3, 5, 0});
    tbl.push_back('{16'h27FF, 3, 5, 0});
    tbl.push_back('{16'h2800, 0, 5, 1});
    tbl.push_back('{16'h3000, 0, 5, 1});
    tbl.push_back('{16'h3800, 0, 5, 1});
    tbl.push_back('{16'h0000, 0, 5, 1});
    tbl.push_back('{16'h1800, 0, 5, 1});
    tbl.push_back('{16'h4000, 1, 3, 0});

    reset_n = 1'b0;
    start = 1'b0;
    mb_is_I4x4 = 1'b0;
    bits_avail = 1'b0;
    BitStream_buffer_output = 16'hFFFF;
    exp_mode = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_state", mb_pred_state, 0);
    chk("rst_blk", luma4x4BlkIdx, 0);
    chk("rst_chroma", intra_chroma_pred_mode, 0);
    chk("rst_pc", pc_advance, 0);
    chk("rst_done", mb_pred_done, 0);
    chk("rst_err", mb_pred_error, 0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // all flags 1, chroma 1xxxx, window always full
    build(1, 1, 0);
    run_mb(1, 100, -1, dc);
    chk("latency_all_flags", dc, 18);

    // block 3 carries flag 0 and rem 3
    build(1, 2, -1);
    run_mb(1, 100, -1, dc);
    chk("latency_one_rem", dc, 19);

    // I16x16 chroma decode table
    last_mode = exp_mode;
    foreach (tbl[i]) begin
      start = 1'b1;
      mb_is_I4x4 = 1'b0;
      bits_avail = 1'b1;
      BitStream_buffer_output = tbl[i].win;
      #1;
      chk("tbl_idle", mb_pred_state, 0);
      @(posedge clk); #1;
      start = 1'b0;
      #1;
      chk("tbl_state3", mb_pred_state, 3);
      chk("tbl_blk", luma4x4BlkIdx, 0);
      chk("tbl_pc", pc_advance, tbl[i].pc);
      chk("tbl_err", mb_pred_error, tbl[i].err);
      chk("tbl_chroma_old", intra_chroma_pred_mode, last_mode);
      @(posedge clk); #1;
      chk("tbl_state4", mb_pred_state, 4);
      chk("tbl_done", mb_pred_done, 1);
      chk("tbl_chroma", intra_chroma_pred_mode, tbl[i].mode);
      chk("tbl_err_clr", mb_pred_error, 0);
      @(posedge clk); #1;
      chk("tbl_back_idle", mb_pred_state, 0);
      last_mode = tbl[i].mode;
    end
    exp_mode = last_mode;

    // three empty-window cycles after block 7
    build(1, 1, -1);
    run_mb(1, 100, 7, dc);
    chk("latency_stall", dc, 21);

    // randomized macroblocks and window availability
    for (int n = 0; n < 40; n++) begin
      bit i4;
      i4 = $urandom_range(0, 1);
      build(i4, 0, -1);
      run_mb(i4, 70, -1, dc);
    end

    // reset in the middle of the luma loop, then restart
    start = 1'b1;
    mb_is_I4x4 = 1'b1;
    bits_avail = 1'b1;
    BitStream_buffer_output = 16'h8000;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    chk("pre_rst_state", mb_pred_state, 1);
    chk("pre_rst_blk", luma4x4BlkIdx, 9);
    reset_n = 1'b0;
    @(posedge clk); #1;
    chk("mid_rst_state", mb_pred_state, 0);
    chk("mid_rst_blk", luma4x4BlkIdx, 0);
    chk("mid_rst_chroma", intra_chroma_pred_mode, 0);
    chk("mid_rst_pc", pc_advance, 0);
    chk("mid_rst_flag", prev_intra4x4_pred_mode_flag, 0);
    reset_n = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    #1;
    chk("restart_state", mb_pred_state, 1);
    chk("restart_blk", luma4x4BlkIdx, 0);
    chk("restart_pc", pc_advance, 1);
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    chk("final_idle", mb_pred_state, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
